sram_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port synchronous SRAM between the instruction-fetch port and the data (load/store) port of the pipeline. Requesters use a req/addr_ok/data_ok handshake. The SRAM side is a plain en/wen/addr/wdata/rdata port with one-cycle read latency. The block sits between the IF/MEM stages and the unified memory, and issues at most one access per cycle.

---
 rtl/sram_arbiter_pkg.sv | 26 ++
 rtl/sram_arb_grant.sv | 113 +++++++++++
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
//   Shared definitions for the two-requester SRAM arbiter.
//   - Owner encodings used by the response register and round-robin state.
//   - Packed request bus {req, wr, wstrb, addr, wdata} (70 bits) used to
//     carry one requester's inputs through the SRAM mux.
package sram_arbiter_pkg;

    localparam logic ARB_OWNER_INST = 1'b0;
    localparam logic ARB_OWNER_DATA = 1'b1;

    localparam int ARB_REQ_BUS_WD = 1 + 1 + 4 + 32 + 32;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

    // Byte write enables presented to the SRAM: reads drive all zeros.
    function automatic logic [3:0] sram_wen_of(input arb_req_t r);
        return r.wr ? r.wstrb : 4'h0;
    endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant
//   Combinational grant decision plus the registered arbitration state.
//   Build option: SRAM_ARB_RR_EN
//     defined   -> round-robin; a 1-bit last_grant register picks the
//                  port that did not win last time on a conflict.
//     undefined -> data has fixed priority; an 8-bit starvation counter
//                  forces inst through once it has lost STARVE_LIMIT
//                  consecutive conflicts.
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     inst_req, data_req     request valids from the two ports
//     grant_inst, grant_data one-hot-or-zero grant, same cycle as req
module sram_arb_grant
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

    logic inst_v;
    logic data_v;
    logic conflict;

    // No grant may be issued while reset is held.
    assign inst_v   = inst_req & ~reset;
    assign data_v   = data_req & ~reset;
    assign conflict = inst_v & data_v;

`ifdef SRAM_ARB_RR_EN

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        last_grant_d = last_grant_q;
        if (conflict) begin
            if (last_grant_q == ARB_OWNER_INST) begin
                grant_data = 1'b1;
            end else begin
                grant_inst = 1'b1;
            end
        end else begin
            grant_inst = inst_v;
            grant_data = data_v;
        end
        // Lone grants also update the history so alternation tracks real use.
        if (grant_data) begin
            last_grant_d = ARB_OWNER_DATA;
        end else if (grant_inst) begin
            last_grant_d = ARB_OWNER_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ARB_OWNER_INST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`else

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt_q;
    logic [7:0] starve_cnt_d;
    logic       force_inst;

    assign force_inst = (starve_cnt_q == LIMIT);

    always_comb begin
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (conflict) begin
            if (force_inst) begin
                grant_inst = 1'b1;
            end else begin
                grant_data = 1'b1;
            end
        end else begin
            grant_inst = inst_v;
            grant_data = data_v;
        end
        // Counter measures consecutive lost conflicts; any inst win or
        // withdrawn inst request restarts the count.
        if (!inst_v || grant_inst) begin
            starve_cnt_d = 8'd0;
        end else if (conflict && grant_data) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) between
//   the instruction-fetch port and the data port. At most one access per
//   cycle. Build option SRAM_ARB_RR_EN selects round-robin arbitration;
//   otherwise data has fixed priority with a starvation guard for inst.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     inst_* / data_*  (in)           req, wr, wstrb, addr, wdata
//     inst_* / data_*  (out)          addr_ok (accept, same cycle as req),
//                                     data_ok (1 cycle after addr_ok),
//                                     rdata (sram_rdata pass-through)
//     sram_en/wen/addr/wdata (out)    SRAM request, zero when idle
//     sram_rdata (in)                 SRAM read data, 1 cycle after sram_en
//   Handshake: a request is accepted in the cycle where req && addr_ok;
//   its data_ok follows exactly one cycle later and cannot be stalled. A
//   losing requester holds req and its inputs stable until accepted.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    arb_req_t inst_bus;
    arb_req_t data_bus;
    logic     grant_inst;
    logic     grant_data;

    logic resp_valid_q;
    logic resp_valid_d;
    logic resp_owner_q;
    logic resp_owner_d;

    assign inst_bus = '{req: inst_req, wr: inst_wr, wstrb: inst_wstrb,
                        addr: inst_addr, wdata: inst_wdata};
    assign data_bus = '{req: data_req, wr: data_wr, wstrb: data_wstrb,
                        addr: data_addr, wdata: data_wdata};

    sram_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_bus.req),
        .data_req   (data_bus.req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (grant_data) begin
            sram_en    = 1'b1;
            sram_wen   = sram_wen_of(data_bus);
            sram_addr  = data_bus.addr;
            sram_wdata = data_bus.wdata;
        end else if (grant_inst) begin
            sram_en    = 1'b1;
            sram_wen   = sram_wen_of(inst_bus);
            sram_addr  = inst_bus.addr;
            sram_wdata = inst_bus.wdata;
        end
    end

    always_comb begin
        resp_valid_d = grant_inst | grant_data;
        resp_owner_d = resp_owner_q;
        if (grant_data) begin
            resp_owner_d = ARB_OWNER_DATA;
        end else if (grant_inst) begin
            resp_owner_d = ARB_OWNER_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= ARB_OWNER_INST;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    // Gating with reset drops a response that was in flight when reset hit.
    assign inst_data_ok = resp_valid_q & (resp_owner_q == ARB_OWNER_INST) & ~reset;
    assign data_data_ok = resp_valid_q & (resp_owner_q == ARB_OWNER_DATA) & ~reset;

    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a behavioural byte-writable SRAM.
//   Unwritten SRAM words read as {addr[15:0], ~addr[15:0]}.
//   Expected arbitration order follows SRAM_ARB_RR_EN when defined.
module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    sram_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen != 4'h0) begin
                logic [31:0] w;
                w = mem_read(sram_addr);
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                end
                mem[sram_addr[31:2]] = w;
            end else begin
                sram_rdata <= mem_read(sram_addr);
            end
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inst(input logic req, input logic wr, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wd);
        inst_req = req; inst_wr = wr; inst_wstrb = strb;
        inst_addr = addr; inst_wdata = wd;
    endtask

    task automatic drive_data(input logic req, input logic wr, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wd);
        data_req = req; data_wr = wr; data_wstrb = strb;
        data_addr = addr; data_wdata = wd;
    endtask

    task automatic idle();
        drive_inst(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Pop the scoreboard and compare with a returned read word.
    task automatic chk_resp(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    logic prev_gi, prev_gd, exp_gd;

    initial begin
        total = 0;
        bad   = 0;
        sram_rdata = 32'h0;
        reset = 1'b1;
        // Requests held during reset must not be granted.
        drive_inst(1'b1, 1'b0, 4'h0, 32'h1C000000, 32'h0);
        drive_data(1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1111_1111);
        next_cycle();
        @(negedge clk);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_wen", 32'(sram_wen), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);

        next_cycle();
        reset = 1'b0;
        idle();

        // ---- idle: no activity ----
        @(negedge clk);
        chk("idle_sram_en", 32'(sram_en), 32'd0);
        chk("idle_sram_wen", 32'(sram_wen), 32'd0);
        chk("idle_sram_addr", sram_addr, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("idle_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("idle_data_data_ok", 32'(data_data_ok), 32'd0);

        // ---- lone inst reads at 0x1C000000 for 3 cycles ----
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_inst(1'b1, 1'b0, 4'hF, 32'h1C000000, 32'h0);
            @(negedge clk);
            chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
            chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
            chk("t1_sram_en", 32'(sram_en), 32'd1);
            chk("t1_sram_wen", 32'(sram_wen), 32'h0);
            chk("t1_sram_addr", sram_addr, 32'h1C000000);
            chk("t1_inst_data_ok", 32'(inst_data_ok), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk_resp("t1_inst_rdata", inst_rdata);
            exp_q.push_back(32'h0000FFFF);
        end
        next_cycle();
        idle();
        @(negedge clk);
        chk("t1_last_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk_resp("t1_last_inst_rdata", inst_rdata);
        chk("t1_tail_sram_en", 32'(sram_en), 32'd0);

        // ---- inst write is honoured ----
        next_cycle();
        drive_inst(1'b1, 1'b1, 4'b1100, 32'h0000_0200, 32'h1234_5678);
        @(negedge clk);
        chk("iw_sram_wen", 32'(sram_wen), 32'hC);
        chk("iw_sram_wdata", sram_wdata, 32'h1234_5678);
        next_cycle();
        idle();
        @(negedge clk);
        chk("iw_inst_data_ok", 32'(inst_data_ok), 32'd1);

        // ---- both requesting every cycle ----
        prev_gi = 1'b0;
        prev_gd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            drive_inst(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
            drive_data(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
            @(negedge clk);
`ifdef SRAM_ARB_RR_EN
            exp_gd = ((i % 2) == 0);
`else
            exp_gd = ((i % 9) != 8);
`endif
            chk($sformatf("t2_data_addr_ok[%0d]", i), 32'(data_addr_ok), 32'(exp_gd));
            chk($sformatf("t2_inst_addr_ok[%0d]", i), 32'(inst_addr_ok), 32'(!exp_gd));
            chk($sformatf("t2_sram_addr[%0d]", i), sram_addr,
                exp_gd ? 32'h0000_3000 : 32'h0000_2000);
            if (i > 0) begin
                chk($sformatf("t2_data_data_ok[%0d]", i), 32'(data_data_ok), 32'(prev_gd));
                chk($sformatf("t2_inst_data_ok[%0d]", i), 32'(inst_data_ok), 32'(prev_gi));
            end
            prev_gd = exp_gd;
            prev_gi = !exp_gd;
        end
        next_cycle();
        idle();
        @(negedge clk);
        chk("t2_tail_data_ok", 32'(data_data_ok), 32'(prev_gd));

        // ---- partial store then load ----
        next_cycle();
        drive_data(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("st_sram_wen", 32'(sram_wen), 32'h3);
        chk("st_sram_addr", sram_addr, 32'h0000_0100);
        chk("st_sram_wdata", sram_wdata, 32'hDEADBEEF);
        next_cycle();
        drive_data(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("st_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("ld_sram_wen", 32'(sram_wen), 32'h0);
        exp_q.push_back(32'h0100BEEF);
        next_cycle();
        idle();
        @(negedge clk);
        chk("ld_data_data_ok", 32'(data_data_ok), 32'd1);
        chk_resp("ld_data_rdata", data_rdata);

        // ---- reset while an inst response is outstanding ----
        next_cycle();
        drive_inst(1'b1, 1'b0, 4'hF, 32'h1C000000, 32'h0);
        @(negedge clk);
        chk("mr_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("mr_inst_addr_ok_rst", 32'(inst_addr_ok), 32'd0);
        chk("mr_sram_en", 32'(sram_en), 32'd0);
        next_cycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("mr_post_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("mr_post_data_data_ok", 32'(data_data_ok), 32'd0);
        // First conflict after reset goes to data in either mode.
        next_cycle();
        drive_inst(1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        drive_data(1'b1, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
        @(negedge clk);
        chk("mr_first_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("mr_first_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("mr_first_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("mr_first_inst_data_ok", 32'(inst_data_ok), 32'd0);

        // ---- final report ----
        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
